// File: rtl/fp_accum_seq.sv
// Sequential FP32 accumulator: one term per cycle, final sum on a valid/ready port.
// Optional output ReLU via `define FP_ACCUM_RELU_EN.
module fp_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  logic [31:0]       w_l;
  logic [31:0]       w_s;
  logic [7:0]        w_d;
  logic [4:0]        w_dc;
  logic [4:0]        w_lz;
  logic [53:0]       w_sh;
  logic [26:0]       w_ml;
  logic [26:0]       w_ms;
  logic [26:0]       w_n;
  logic [27:0]       w_sum;
  logic [24:0]       w_m;
  logic signed [9:0] w_e;
  logic              w_rnd;

  // Normal operands only; caller filters exponent==0.
  always_comb begin
    w_l  = (i_b[30:0] > i_a[30:0]) ? i_b : i_a;
    w_s  = (i_b[30:0] > i_a[30:0]) ? i_a : i_b;
    w_d  = w_l[30:23] - w_s[30:23];
    w_dc = (w_d > 8'd31) ? 5'd31 : w_d[4:0];
    w_sh = {1'b1, w_s[22:0], 30'd0} >> w_dc;
    w_ms = {w_sh[53:28], w_sh[27] | (|w_sh[26:0])};
    w_ml = {1'b1, w_l[22:0], 3'd0};
    if (w_l[31] ^ w_s[31])
      w_sum = {1'b0, w_ml} - {1'b0, w_ms};
    else
      w_sum = {1'b0, w_ml} + {1'b0, w_ms};
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (w_sum[i]) w_lz = 5'(26 - i);
    w_e = signed'({2'b00, w_l[30:23]});
    if (w_sum[27]) begin
      w_n = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e = w_e + 10'sd1;
    end else begin
      w_n = w_sum[26:0] << w_lz;
      w_e = w_e - signed'({5'd0, w_lz});
    end
    // Round to nearest, ties to even
    w_rnd = w_n[2] & (w_n[3] | w_n[1] | w_n[0]);
    w_m   = {1'b0, w_n[26:3]} + {24'd0, w_rnd};
    if (w_m[24]) w_e = w_e + 10'sd1;
    if (w_sum == 28'd0 || w_e <= 10'sd0)
      o_y = 32'h0;
    else if (w_e >= 10'sd255)
      o_y = {w_l[31], 8'hFF, 23'd0};
    else
      o_y = {w_l[31], w_e[7:0], w_m[24] ? w_m[23:1] : w_m[22:0]};
  end
endmodule

module fp_accum_seq #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             sum_valid,
  output logic [31:0]      sum_data,
  input  logic             sum_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_rem;
  logic [31:0]      w_add;
  logic [31:0]      w_next;
  logic [31:0]      w_out;

  fp_add u_add (
    .i_a (r_acc),
    .i_b (in_data),
    .o_y (w_add)
  );

  // Zero/denormal terms are consumed but not added; zero acc passes the term through.
  assign w_next = (in_data[30:23] == 8'd0) ? r_acc :
                  (r_acc[30:23] == 8'd0)   ? in_data : w_add;

`ifdef FP_ACCUM_RELU_EN
  assign w_out = w_next[31] ? 32'h0 : w_next;
`else
  assign w_out = w_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= 32'h0;
      r_rem     <= '0;
      in_ready  <= 1'b0;
      sum_valid <= 1'b0;
      sum_data  <= 32'h0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_rem <= len;
          r_acc <= 32'h0;
          busy  <= 1'b1;
          if (len != '0) begin
            r_state  <= ACCUM;
            in_ready <= 1'b1;
          end else begin
            r_state   <= DONE;
            sum_valid <= 1'b1;
            sum_data  <= 32'h0;
          end
        end
        ACCUM: if (in_valid) begin
          r_acc <= w_next;
          r_rem <= r_rem - 1'b1;
          if (r_rem == CNT_W'(1)) begin
            r_state   <= DONE;
            in_ready  <= 1'b0;
            sum_valid <= 1'b1;
            sum_data  <= w_out;
          end
        end
        DONE: if (sum_ready) begin
          r_state   <= IDLE;
          sum_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: vector table, corner sequences, randomized integer sums.
module tb_fp_accum_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        sum_valid;
  logic [31:0] sum_data;
  logic        sum_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] terms [0:15];

  always #5 clk = ~clk;

  fp_accum_seq #(.CNT_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sum_valid (sum_valid),
    .sum_data  (sum_data),
    .sum_ready (sum_ready),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef FP_ACCUM_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // Exact FP32 encoding of a small integer
  function automatic logic [31:0] int_to_fp(input int v);
    int m;
    int p;
    logic [31:0] f;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++)
      if ((m >> i) != 0) p = i;
    f = 32'(m) << (23 - p);
    return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p), f[22:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [31:0] expv, input bit gaps, input string nm);
    int cnt;
    int k;
    bit xfer;
    cnt = 0;
    k = 0;
    len = n[9:0];
    start = 1'b1;
    sum_ready = 1'b0;
    in_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
    in_data = terms[0];
    do begin
      xfer = in_ready && in_valid;
      tick();
      start = 1'b0;
      cnt++;
      if (xfer) k++;
      in_data = (k < 16) ? terms[k] : 32'h0;
      in_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
    end while (!sum_valid && cnt < 200);
    chk({nm, " done"}, 32'(sum_valid), 32'd1);
    if (!gaps) chk({nm, " latency"}, cnt, n + 1);
    chk({nm, " xfers"}, k, n);
    chk({nm, " sum"}, sum_data, relu(expv));
    chk({nm, " busy"}, 32'(busy), 32'd1);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk({nm, " idle busy"}, 32'(busy), 32'd0);
    chk({nm, " idle valid"}, 32'(sum_valid), 32'd0);
  endtask

  typedef struct {
    int                n;
    logic [3:0][31:0]  t;
    logic [31:0]       e;
    string             nm;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{3, {32'h0, 32'h40000000, 32'h3F800000, 32'h3F800000}, 32'h40800000, "basic"};
    vt[1]  = '{3, {32'h0, 32'h80000000, 32'h40400000, 32'h00000000}, 32'h40400000, "zeros"};
    vt[2]  = '{2, {32'h0, 32'h0, 32'hC0400000, 32'h3F800000}, 32'hC0000000, "neg"};
    vt[3]  = '{0, {32'h0, 32'h0, 32'h0, 32'h0}, 32'h00000000, "len0"};
    vt[4]  = '{2, {32'h0, 32'h0, 32'h3E800000, 32'h3FC00000}, 32'h3FE00000, "frac"};
    vt[5]  = '{2, {32'h0, 32'h0, 32'h33800000, 32'h3F800000}, 32'h3F800000, "tie_even"};
    vt[6]  = '{2, {32'h0, 32'h0, 32'h33C00000, 32'h3F800000}, 32'h3F800001, "round_up"};
    vt[7]  = '{2, {32'h0, 32'h0, 32'h3F800000, 32'h4B800000}, 32'h4B800000, "big_tie"};
    vt[8]  = '{3, {32'h0, 32'h40A00000, 32'hC0400000, 32'h40400000}, 32'h40A00000, "cancel"};
    vt[9]  = '{2, {32'h0, 32'h0, 32'h3F800000, 32'h00000123}, 32'h3F800000, "denorm"};
    vt[10] = '{2, {32'h0, 32'h0, 32'hBF400000, 32'h3F800000}, 32'h3E800000, "norm_left"};

    rst = 1'b1;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_data = '0;
    sum_ready = 1'b0;
    #12;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst sum_valid", 32'(sum_valid), 32'd0);
    chk("rst sum_data", sum_data, 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 4; i++) terms[i] = vt[v].t[i];
      run(vt[v].n, vt[v].e, 1'b0, vt[v].nm);
    end

    // Gaps then held sum under backpressure
    len = 10'd2;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h3F800000;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp gap busy", 32'(busy), 32'd1);
    chk("bp gap valid", 32'(sum_valid), 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp hold valid", 32'(sum_valid), 32'd1);
      chk("bp hold data", sum_data, 32'h40000000);
      tick();
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk("bp idle busy", 32'(busy), 32'd0);

    // len=0 with starts during DONE
    len = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0 valid", 32'(sum_valid), 32'd1);
    chk("len0 data", sum_data, 32'h0);
    len = 10'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign start valid", 32'(sum_valid), 32'd1);
    chk("ign start busy", 32'(busy), 32'd1);
    chk("ign start ready", 32'(in_ready), 32'd0);
    start = 1'b1;
    sum_ready = 1'b1;
    tick();
    start = 1'b0;
    sum_ready = 1'b0;
    chk("start+ack busy", 32'(busy), 32'd0);
    tick();
    chk("start+ack stays idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-run
    len = 10'd4;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h3F800000;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid rst in_ready", 32'(in_ready), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst valid", 32'(sum_valid), 32'd0);
    chk("mid rst data", sum_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    terms[0] = 32'h3F800000;
    run(1, 32'h3F800000, 1'b0, "post_rst");

    // Random integer sums against exact arithmetic
    for (int it = 0; it < 24; it++) begin
      int n;
      int s;
      int v;
      n = $urandom_range(12, 1);
      s = 0;
      for (int i = 0; i < n; i++) begin
        if ($urandom % 6 == 0) begin
          case ($urandom % 4)
            0: terms[i] = 32'h00000000;
            1: terms[i] = 32'h80000000;
            2: terms[i] = 32'h00000123;
            default: terms[i] = 32'h80400000;
          endcase
        end else begin
          v = int'($urandom_range(200, 0)) - 100;
          terms[i] = int_to_fp(v);
          s += v;
        end
      end
      run(n, int_to_fp(s), (it % 2) == 1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Sequential accumulation controller for the neuron dot-product datapath.
- Consumes a stream of 32-bit single-precision terms (products from the multiplier stage) and keeps a running-sum register.
- Each cycle it presents the running sum and the accepted term to one combinational FP_adder instance, then registers the adder output back into the running sum.
- After LEN terms it presents the final sum (one neuron pre-activation) to the downstream layer buffer over a valid/ready handshake.

Parameters:
- CNT_W, 10, width of term counter and len input (max 1023 terms; 784 for a 28x28 input).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a new accumulation; honoured in IDLE only.
- len  in  CNT_W  number of terms; sampled on accepted start.
- in_valid  in  1  term valid.
- in_data  in  32  FP term (seee_eeee_emmm_..._mmmm).
- in_ready  out  1  block can accept a term this cycle.
- sum_valid  out  1  final sum available.
- sum_data  out  32  final FP sum.
- sum_ready  in  1  downstream accepts sum.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset: state=IDLE; acc=32'h0; remaining count=0; in_ready=0, sum_valid=0, sum_data=32'h0, busy=0.
- States:
  - IDLE: on start, load remaining=len and acc=32'h0.
    - len!=0 -> ACCUM.
    - len==0 -> DONE directly; sum is 32'h0.
  - ACCUM: in_ready=1. A term transfers when in_valid && in_ready.
    - On each transfer: acc <= next_acc and remaining decrements.
    - When remaining==1 at transfer -> DONE on the next edge.
    - No transfer leaves state and acc unchanged; gaps are allowed.
  - DONE: in_ready=0, sum_valid=1, sum_data=acc; all held stable until sum_ready.
    - On sum_valid && sum_ready -> IDLE.
- next_acc rules (FP_adder has no zero or denormal support, so this block handles exponent==0 explicitly):
  - in_data[30:23]==0: next_acc=acc. Term is +/-0 or denormal and counts as a consumed term.
  - else acc[30:23]==0: next_acc=in_data (passthrough).
  - else: next_acc=FP_adder(acc, in_data).
- Latency:
  - One cycle per term.
  - sum_valid rises the cycle after the last transfer.
  - Minimum start-to-sum_valid latency is len+1 cycles with in_valid held high.
- start outside IDLE is ignored; len is not resampled.
- in_valid outside ACCUM is ignored; in_ready=0 in that case.
- Reset asserted mid-operation: immediate return to reset values; the partial sum is discarded.
- Counter never wraps: remaining only decrements in ACCUM with remaining>=1.
- start and sum_ready in the same DONE cycle: only the sum handshake completes. start is not honoured until IDLE, so a new start needs at least one IDLE cycle.
- busy = (state!=IDLE).

Optional Feature:
- Macro: FP_ACCUM_RELU_EN.
- Defined: ReLU is applied at the output. sum_data = (acc[31]==1) ? 32'h0 : acc. Negative zero also maps to 32'h0. acc itself is unmodified.
- Undefined: sum_data = acc exactly, and no extra logic is synthesized.

Test Plan:
- Basic sum: start len=3; terms 0x3F800000, 0x3F800000, 0x40000000 with in_valid held high -> sum_valid 4 cycles after start; sum_data=0x40800000 (4.0).
- Zero handling: len=3; terms 0x00000000, 0x40400000, 0x80000000 -> sum_data=0x40400000; exactly 3 transfers consumed.
- Backpressure and gaps: len=2; in_valid toggles 1,0,0,1; sum_ready held 0 for 5 cycles -> sum_data stable at 0x40000000 for 1.0+1.0 while held; IDLE one cycle after sum_ready=1.
- len=0 and ignored start: start len=0 -> DONE next cycle, sum_data=0x0. A second start pulse during DONE is ignored; busy=1 until the handshake.
- Reset mid-run: len=4; assert rst after 2 transfers -> all outputs return to reset values asynchronously. A fresh start len=1 with term 0x3F800000 -> sum 0x3F800000.
- ReLU (macro defined): len=2; terms 0x3F800000, 0xC0400000 (1.0 and -3.0) -> sum_data=0x00000000. Macro undefined -> sum_data=0xC0000000.
